// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, display window and lock status from an incoming hsync/vsync pair,
// counting timing deviations from the expected 640x480@60 raster.
module vga_sync_decoder #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_BOTTOM    = 10,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       locked,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       display_on,
    output logic       frame_start,
    output logic [1:0] state,
    output logic [7:0] err_count
);

    localparam logic [9:0]  H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0]  V_VIS        = 10'(V_DISPLAY);
    localparam logic [10:0] WD_LIMIT     = 11'(2 * H_TOTAL);
    localparam int unsigned GW           = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LOCK  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2
    } state_e;

    logic          hs_s1_q, hs_s2_q, hs_s3_q;
    logic          vs_s1_q, vs_s2_q, vs_s3_q;
    logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0]    pix_x_q, pix_y_q;
    logic [10:0]   wd_q, wd_d;
    state_e        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          err_seen_q, err_seen_d;
    logic [7:0]    err_count_q, err_count_d;

    logic       hs_rise, hs_fall, vs_rise;
    logic       h_wrap, wd_expired, err;
    logic [9:0] h_free, v_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_s1_q     <= 1'b0;
            hs_s2_q     <= 1'b0;
            hs_s3_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            vs_s3_q     <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            wd_q        <= '0;
            state_q     <= StSearch;
            good_q      <= '0;
            err_seen_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            hs_s1_q     <= hsync_in;
            hs_s2_q     <= hs_s1_q;
            hs_s3_q     <= hs_s2_q;
            vs_s1_q     <= vsync_in;
            vs_s2_q     <= vs_s1_q;
            vs_s3_q     <= vs_s2_q;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            pix_x_q     <= h_cnt_q;
            pix_y_q     <= v_cnt_q;
            wd_q        <= wd_d;
            state_q     <= state_d;
            good_q      <= good_d;
            err_seen_q  <= err_seen_d;
            err_count_q <= err_count_d;
        end
    end

    // Checks compare the count the freewheeling raster would reach on this edge, so a sync edge
    // detected exactly on schedule matches H_SYNC_START / H_SYNC_END / V_SYNC_START.
    always_comb begin
        hs_rise = hs_s2_q & ~hs_s3_q;
        hs_fall = ~hs_s2_q & hs_s3_q;
        vs_rise = vs_s2_q & ~vs_s3_q;

        h_wrap  = (h_cnt_q == H_LAST);
        h_free  = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_free  = v_cnt_q;
        if (h_wrap) begin
            v_free = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
        h_cnt_d = hs_rise ? H_SYNC_START : h_free;
        v_cnt_d = vs_rise ? V_SYNC_START : v_free;

        err = (state_q != StSearch) &&
              ((hs_rise && (h_free != H_SYNC_START)) ||
               (hs_fall && (h_free != H_SYNC_END)) ||
               (vs_rise && (v_free != V_SYNC_START)));

        err_count_d = err_count_q;
        if (err && (err_count_q != 8'hff)) begin
            err_count_d = err_count_q + 8'd1;
        end

        wd_expired = (wd_q == WD_LIMIT);
        if (hs_rise) begin
            wd_d = '0;
        end else if (wd_expired) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 11'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        err_seen_d = err_seen_q;
        if (wd_expired) begin
            state_d    = StSearch;
            good_d     = '0;
            err_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (vs_rise) begin
                        state_d    = StAcquire;
                        good_d     = '0;
                        err_seen_d = 1'b0;
                    end
                end
                StAcquire: begin
                    if (vs_rise) begin
                        err_seen_d = 1'b0;
                        if (err || err_seen_q) begin
                            good_d = '0;
                        end else if (good_q + GW'(1) == GOOD_LOCK) begin
                            good_d  = GOOD_LOCK;
                            state_d = StLocked;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else if (err) begin
                        good_d     = '0;
                        err_seen_d = 1'b1;
                    end
                end
                StLocked: begin
                    if (err) begin
                        state_d    = StAcquire;
                        good_d     = '0;
                        err_seen_d = ~vs_rise;
                    end
                end
                default: begin
                    state_d = StSearch;
                    good_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked      = (state_q == StLocked);
        pix_x       = pix_x_q;
        pix_y       = pix_y_q;
        display_on  = locked && (pix_x_q < H_VIS) && (pix_y_q < V_VIS);
        frame_start = locked && (pix_x_q == 10'd0) && (pix_y_q == 10'd0);
        state       = state_q;
        err_count   = err_count_q;
    end

endmodule
